// File: rtl/seg_595_if.sv
// seg_595_if: display data inputs and 74HC595 pin bundle for seg_595_scan_param
interface seg_595_if #(
    parameter int DIGITS = 6
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   point;
    logic                sign;
    logic                blank_lz;
    logic                seg_en;
    logic                ds;
    logic                shcp;
    logic                stcp;
    logic                oe;
    logic                frame_done;
    modport master (output data, point, sign, blank_lz, seg_en, input ds, shcp, stcp, oe, frame_done);
    modport slave  (input data, point, sign, blank_lz, seg_en, output ds, shcp, stcp, oe, frame_done);
endinterface

// File: rtl/seg_595_scan_param.sv
// seg_595_scan_param: multiplexed seven-segment scanner serialising {segments, select} into a 74HC595 chain
module seg_595_scan_param #(
    parameter int          DIGITS         = 6,
    parameter logic [15:0] SCAN_CNT       = 16'd49999,
    parameter int          SHCP_DIV       = 1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    seg_595_if.slave bus
);
    localparam int NW = 8 + DIGITS;
    localparam int BW = $clog2(NW);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int DW = SHCP_DIV > 1 ? $clog2(SHCP_DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NW - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(SHCP_DIV - 1);
    localparam logic [6:0] GLYPH [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                          7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t              state_q, state_d;
    logic [15:0]         scan_q, scan_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DW-1:0]       div_q, div_d;
    logic [NW-1:0]       sr_q, sr_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic [DIGITS-1:0]   point_q, point_d;
    logic                sign_q, sign_d, blank_q, blank_d;
    logic                ds_q, ds_d, shcp_q, shcp_d, stcp_q, stcp_d;
    logic                oe_q, oe_d, frame_done_q, frame_done_d;
    logic                wrap, frame_start, last, lz;
    logic [3:0]          nib;
    logic [7:0]          seg, tx;
    logic [NW-1:0]       word;

    always_comb begin
        wrap         = scan_q == SCAN_CNT;
        frame_start  = wrap && idx_q == '0;
        last         = idx_q == LAST_IDX;
        // the digit-0 word is built from the values being captured this very cycle
        data_d       = frame_start ? bus.data : data_q;
        point_d      = frame_start ? bus.point : point_q;
        sign_d       = frame_start ? bus.sign : sign_q;
        blank_d      = frame_start ? bus.blank_lz : blank_q;
        nib          = data_d[{idx_q, 2'b00} +: 4];
        lz           = blank_d && idx_q != '0 && (data_d >> {idx_q, 2'b00}) == '0;
        seg          = {point_d[idx_q], sign_d && last ? 7'h40 : lz ? 7'h00 : GLYPH[nib]};
        tx           = SEG_ACTIVE_LOW ? ~seg : seg;
        word         = {tx, DIGITS'(1) << idx_q};
        scan_d       = wrap ? '0 : scan_q + 16'd1;
        idx_d        = wrap ? (last ? '0 : idx_q + IW'(1)) : idx_q;
        oe_d         = ~bus.seg_en;
        state_d      = state_q;
        bit_d        = bit_q;
        div_d        = div_q;
        sr_d         = sr_q;
        shcp_d       = shcp_q;
        stcp_d       = stcp_q;
        frame_done_d = 1'b0;
        if (state_q == IDLE) begin
            if (wrap) begin
                state_d = SHIFT;
                sr_d    = word;
                bit_d   = '0;
                div_d   = '0;
                shcp_d  = 1'b0;
            end
        end else if (div_q != LAST_DIV) begin
            div_d = div_q + DW'(1);
        end else begin
            div_d = '0;
            if (state_q == LATCH) begin
                stcp_d       = 1'b0;
                state_d      = IDLE;
                frame_done_d = idx_q == '0;
            end else if (!shcp_q) begin
                shcp_d = 1'b1;
            end else begin
                shcp_d = 1'b0;
                if (bit_q == LAST_BIT) begin
                    state_d = LATCH;
                    stcp_d  = 1'b1;
                end else begin
                    bit_d = bit_q + BW'(1);
                    sr_d  = sr_q << 1;
                end
            end
        end
        ds_d = sr_d[NW-1];
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            scan_q       <= '0;
            idx_q        <= '0;
            bit_q        <= '0;
            div_q        <= '0;
            sr_q         <= '0;
            data_q       <= '0;
            point_q      <= '0;
            sign_q       <= 1'b0;
            blank_q      <= 1'b0;
            ds_q         <= 1'b0;
            shcp_q       <= 1'b0;
            stcp_q       <= 1'b0;
            oe_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            scan_q       <= scan_d;
            idx_q        <= idx_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            sr_q         <= sr_d;
            data_q       <= data_d;
            point_q      <= point_d;
            sign_q       <= sign_d;
            blank_q      <= blank_d;
            ds_q         <= ds_d;
            shcp_q       <= shcp_d;
            stcp_q       <= stcp_d;
            oe_q         <= oe_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.ds         = ds_q;
    assign bus.shcp       = shcp_q;
    assign bus.stcp       = stcp_q;
    assign bus.oe         = oe_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_595_scan_param.sv
// tb_seg_595_scan_param: directed frames with a scoreboard of expected 14-bit chain words
module tb_seg_595_scan_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_fails = 0;
    int          lat_total = 0;
    int          nlat = 0;
    int          nbits;
    logic [13:0] cap;
    logic [13:0] exp_w;
    logic        shcp_p, stcp_p, done_p;
    logic [13:0] sb [$];

    seg_595_if #(.DIGITS(6)) bus ();

    seg_595_scan_param #(
        .DIGITS(6),
        .SCAN_CNT(16'd49),
        .SHCP_DIV(1),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ds"}, {31'd0, bus.ds}, 32'd0);
        check({tag, "_shcp"}, {31'd0, bus.shcp}, 32'd0);
        check({tag, "_stcp"}, {31'd0, bus.stcp}, 32'd0);
        check({tag, "_oe"}, {31'd0, bus.oe}, 32'd1);
        check({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
    endtask

    // segs holds transmitted segment bytes {d5,d4,d3,d2,d1,d0}
    task automatic push_frame(input logic [47:0] segs);
        for (int i = 0; i < 6; i++) sb.push_back({segs[8*i +: 8], 6'(1 << i)});
    endtask

    task automatic set_in(input logic [23:0] d, input logic [5:0] p, input logic s, input logic b);
        bus.data     = d;
        bus.point    = p;
        bus.sign     = s;
        bus.blank_lz = b;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 400);
        check("frame_done_seen", {31'd0, bus.frame_done}, 32'd1);
    endtask

    task automatic expect_first_rise(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, "_oe"}, {31'd0, bus.oe}, 32'd0);
        end while (!bus.shcp && n < 200);
        check(tag, n, 51);
    endtask

    initial begin
        nbits  = 0;
        cap    = '0;
        shcp_p = 1'b0;
        stcp_p = 1'b0;
        done_p = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                nbits  = 0;
                nlat   = 0;
                shcp_p = 1'b0;
                stcp_p = 1'b0;
                done_p = 1'b0;
            end else begin
                check("shcp_stcp_overlap", {31'd0, bus.shcp & bus.stcp}, 32'd0);
                if (bus.shcp && !shcp_p) begin
                    cap = {cap[12:0], bus.ds};
                    nbits++;
                end
                if (bus.stcp && !stcp_p) begin
                    lat_total++;
                    nlat++;
                    check("bits_per_word", nbits, 14);
                    nbits = 0;
                    exp_w = sb.size() != 0 ? sb.pop_front() : ~cap;
                    check("chain_word", {18'd0, cap}, {18'd0, exp_w});
                end
                if (bus.frame_done) begin
                    check("frame_done_width", {31'd0, done_p}, 32'd0);
                    if (!done_p) begin
                        check("slots_per_frame", nlat, 6);
                        nlat = 0;
                    end
                end
                shcp_p = bus.shcp;
                stcp_p = bus.stcp;
                done_p = bus.frame_done;
            end
        end
    end

    initial begin
        int   k, n, lat0;
        logic p;
        set_in(24'h123456, 6'd0, 1'b0, 1'b0);
        bus.seg_en = 1'b1;
        push_frame(48'hF9A4B0999282);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        expect_first_rise("first_shcp_rise");
        wait_done();
        set_in(24'h000042, 6'd0, 1'b0, 1'b1);
        push_frame(48'hFFFFFFFF99A4);
        wait_done();
        set_in(24'h00A0F0, 6'b100001, 1'b0, 1'b0);
        push_frame(48'h40C088C08E40);
        wait_done();
        set_in(24'h000000, 6'b000100, 1'b1, 1'b1);
        push_frame(48'hBFFFFF7FFFC0);
        wait_done();
        set_in(24'h111111, 6'd0, 1'b0, 1'b0);
        push_frame(48'hF9F9F9F9F9F9);
        repeat (180) @(negedge clk);
        set_in(24'h222222, 6'd0, 1'b0, 1'b0);
        push_frame(48'hA4A4A4A4A4A4);
        bus.seg_en = 1'b0;
        @(negedge clk);
        check("oe_disable", {31'd0, bus.oe}, 32'd1);
        bus.seg_en = 1'b1;
        @(negedge clk);
        check("oe_enable", {31'd0, bus.oe}, 32'd0);
        wait_done();
        wait_done();
        set_in(24'h123456, 6'd0, 1'b0, 1'b0);
        p = bus.shcp;
        k = 0;
        n = 0;
        while (k < 5 && n < 400) begin
            @(negedge clk);
            n++;
            if (bus.shcp && !p) k++;
            p = bus.shcp;
        end
        check("mid_shift_rises", k, 5);
        lat0 = lat_total;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("mid_shift_reset");
        rst_n = 1'b1;
        push_frame(48'hF9A4B0999282);
        expect_first_rise("restart_shcp_rise");
        check("no_stcp_after_abort", lat_total, lat0);
        wait_done();
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/seg_595_scan_param.md
# seg_595_scan_param

Parametrised multiplexed seven-segment driver for displays behind a chain of 74HC595 shift registers. It is the successor to the fixed six-digit `seg_595_dynamic` path and adds:

- configurable digit count, scan period and shift-clock rate;
- hex glyphs, decimal points, a sign digit and leading-zero blanking;
- tear-free frame-synchronous input sampling.

It sits between the data generator and the board's 595 pins: ds, shcp, stcp, oe.

## Interface
- DIGITS, 6: number of digits; the chain carries 8 segment bits plus DIGITS select bits.
- SCAN_CNT, 16'd49999: sys_clk cycles per digit slot minus 1. Constraint: SCAN_CNT+1 ≥ 2·SHCP_DIV·(8+DIGITS)+SHCP_DIV+1.
- SHCP_DIV, 1: sys_clk cycles per shcp half-period (≥1).
- SEG_ACTIVE_LOW, 1: 1 inverts the segment bits (common anode). Select bits are always active-high one-hot.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  synchronous active-low reset.
- data  in  4·DIGITS  hex nibbles; nibble i = digit i; digit 0 is rightmost.
- point  in  DIGITS  decimal-point enable per digit.
- sign  in  1  forces digit DIGITS-1 to '-'.
- blank_lz  in  1  leading-zero blanking enable.
- seg_en  in  1  display enable.
- ds  out  1  serial data to the 595 chain.
- shcp  out  1  shift clock.
- stcp  out  1  storage latch clock.
- oe  out  1  595 output enable, active-low.
- frame_done  out  1  one-cycle pulse after digit DIGITS-1 is latched.

## Operation
- **Shadow registers.** data, point, sign and blank_lz are copied into shadow registers on the cycle the scan counter wraps while the digit index is 0, i.e. at the start of each frame. Mid-frame input changes never appear within the current frame.
- **Glyph encoding.** Segment byte seg[7:0] = {dp, g, f, e, d, c, b, a}. Nibble values 0–F map to 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
  - '-' = 40.
  - dp = point[i].
- **Leading-zero blanking.** When blank_lz=1, zero digits from DIGITS-1 downward, up to the first nonzero digit, get g..a = 0. Digit 0 is never blanked. dp still follows point[i] on a blanked digit.
- **Sign.** sign overrides digit DIGITS-1 to '-' regardless of its nibble and of blanking.
- **Polarity.** With SEG_ACTIVE_LOW=1 the transmitted segment byte is ~seg.
- **Shift word.** W = {seg', sel}, 8+DIGITS bits, where sel = one-hot (1 << digit index). W is shifted MSB first, so after latching, sel sits in the first 595 stages.
- **Scan counter.** Counts 0..SCAN_CNT and wraps. On each wrap the block starts shifting the word for the current digit index, then increments the index modulo DIGITS.
- **FSM.**
  - IDLE: waits for the scan wrap, then goes to SHIFT.
  - SHIFT: for each bit, ds is updated on entry to the low phase; shcp is low for SHIFT_DIV… held low for SHCP_DIV cycles, then high for SHCP_DIV cycles, so the 595 samples ds on the rising edge. After the 8+DIGITS-th high phase, shcp returns low and the FSM goes to LATCH.
  - LATCH: stcp is high for SHCP_DIV cycles, then the FSM returns to IDLE. frame_done pulses on the LATCH→IDLE cycle when the latched index was DIGITS-1.
- **Output enable.** oe = ~seg_en, registered, one-cycle delay. Scanning continues while seg_en=0.
- **Bit and digit counters.** The bit counter width is clog2(8+DIGITS). The digit index wraps from DIGITS-1 to 0.

## Timing
- **Reset values.** ds=0, shcp=0, stcp=0, oe=1, frame_done=0. Scan counter, digit index, bit counter and shadow registers are all 0; FSM is in IDLE.
- **Reset is synchronous.** Asserting sys_rst_n low mid-SHIFT or mid-LATCH aborts the transfer: all outputs take their reset values at the next edge, and no stcp pulse is issued.
- **First transfer.** The first scan wrap occurs SCAN_CNT+1 cycles after reset release. Shifting starts on that cycle and takes 2·SHCP_DIV·(8+DIGITS) cycles. stcp rises on the following cycle.
- **Latency.** An input change becomes visible at the first frame start after it, i.e. at most (DIGITS+1)·(SCAN_CNT+1) cycles later.
- **ds stability.** ds is stable for SHCP_DIV cycles before each shcp rise and for SHCP_DIV cycles after it. stcp is never high while shcp is high.

## Test plan
All scenarios use DIGITS=6, SCAN_CNT=49, SHCP_DIV=1, SEG_ACTIVE_LOW=1, seg_en=1.

1. **Reset.** Hold sys_rst_n=0 for 3 cycles -> ds=shcp=stcp=0, oe=1, frame_done=0. After release, oe=0 one cycle later; the first shcp rise occurs 51 cycles after release.
2. **Basic frame.** data=24'h123456, point=0, sign=0, blank_lz=0 -> the first 14 bits sampled on shcp rises are {~7D, 000001} = 82_01 pattern (10000010_000001); the next slot is {~6D, 000010}. After 6 slots frame_done pulses once.
3. **Leading-zero blanking.** data=24'h000042, blank_lz=1 -> digits 5..2 carry FF; digit 1 carries ~66 = 99; digit 0 carries ~5B = A4.
4. **Sign and point.** data=24'h000000, sign=1, point=6'b000100, blank_lz=1 -> digit 5 = ~40 = BF; digit 2 = ~80 = 7F; digit 0 = ~3F = C0.
5. **Shadow register.** Change data from 24'h111111 to 24'h222222 during slot 3 -> slots 3–5 still send ~06 = F9; the next frame sends ~5B = A4.
6. **Reset mid-shift.** Pull reset low after the 5th shcp rise -> no stcp pulse occurs. After release, the transfer restarts at digit 0 after 51 cycles.
